acc_unit_n: RTL and testbench
=============================

# acc_unit_n

Parametrised accumulator execution unit: a bank of NACC accumulators of WIDTH bits, an ALU operating on accumulator[sel] and the input bus, registered carry/zero flags, and a multi-cycle shift-add multiply. Operations enter through a valid/ready handshake, and each completion is announced with a one-cycle result strobe. It replaces the fixed 4-bit single-accumulator datapath at the top of the processor, which drives the input bus and gates the output bus.

## Interface
Parameters:
- WIDTH, 4: datapath and accumulator width (≥2).
- NACC, 4: number of accumulators (≥1); SELW = max(1, $clog2(NACC)).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  op/sel/bus_in valid this cycle.
- in_ready  out  1  unit can accept an op; high only in IDLE.
- op  in  3  operation code (see Operation).
- sel  in  SELW  target accumulator; also selects acc_out.
- bus_in  in  WIDTH  operand B.
- out_en  in  1  output bus enable.
- bus_out  out  WIDTH  last result when out_en=1, else all zeros (no tristate).
- acc_out  out  WIDTH  accumulator[sel], combinational read of registered state.
- res_valid  out  1  one-cycle pulse: result, acc, C, Z updated.
- busy  out  1  multiply in progress (= ~in_ready).
- C  out  1  registered carry/borrow/overflow flag.
- Z  out  1  registered zero flag.

## Operation
- Accept: in_valid & in_ready at a rising edge. A = acc[sel], B = bus_in, both captured at accept.
- Op codes and results (R = WIDTH-bit result):
  - 0 LOAD: R=B. C=0.
  - 1 ADD: R=A+B. C=carry out.
  - 2 SUB: R=A−B mod 2^WIDTH. C=1 iff A<B (borrow).
  - 3 AND, 4 OR, 5 XOR: bitwise. C=0.
  - 6 CMP: computes A−B. C and Z as for SUB. Accumulator and result register unchanged.
  - 7 MUL: P=A·B (2·WIDTH bits). R=P[WIDTH-1:0]. C=1 iff P[2W-1:W]≠0.
- Z=1 iff R==0. Z is not computed from the full product for MUL.
- Ops 0–5 and 7 write R into acc[sel_captured] and into the result register. The flags update on every completion.
- FSM states:
  - IDLE: in_ready=1. Accepting ops 0–6 completes them at the accept edge and the state stays IDLE. Accepting MUL goes to MUL.
  - MUL: in_ready=0. Performs one shift-add step per cycle, counting cnt from WIDTH−1 down to 0. The step with cnt==0 writes the results, pulses res_valid and returns to IDLE.
- Accumulators not selected are never modified.
- Reset: all accumulators, the result register, C, Z and res_valid are cleared to 0, state goes to IDLE and the multiply counter is cleared. Reset overrides any accept in the same cycle.

## Timing
- Ops 0–6 accepted at edge k: the new acc, C and Z are visible after edge k, and res_valid=1 for the cycle k..k+1.
- Ops 0–6 run back-to-back, one per cycle, at full throughput.
- MUL accepted at edge k: in_ready=0 for cycles k..k+WIDTH. Results are written at edge k+WIDTH, with res_valid=1 during the following cycle, and in_ready returns high in that same cycle. Latency is WIDTH cycles.
- Changing in_valid, sel or bus_in while busy has no effect.
- A new op accepted in the cycle where res_valid=1 sees the just-written acc.
- acc_out and bus_out are combinational from registers and out_en/sel, so they have zero latency.
- Reset mid-MUL: the operation is aborted, no res_valid is produced, and the target accumulator reads 0 after the reset edge.
- All outputs are 0 out of reset, except in_ready=1.

## Structure
- Package acc_unit_pkg:
  - op_t enum: LOAD, ADD, SUB, AND, OR, XOR, CMP, MUL = 0..7.
  - state_t enum: IDLE, MUL.
- Sub-module acc_mul_seq:
  - Function: WIDTH-parametrised shift-add multiplier.
  - Inputs: start, a, b. Outputs: done (single-cycle pulse), product[2W-1:0].
  - Clock and reset: same clk and reset as the parent.
- Top level: the accumulator array, the single-cycle ALU as combinational logic, flag and result registers, and the FSM.

## Test plan
WIDTH=4, NACC=4:
- Reset check: reset pulse → every acc=0, C=0, Z=0, res_valid=0, in_ready=1, bus_out=0.
- LOAD, ADD carry: LOAD 9 to acc1, then ADD 8 to acc1 → acc1=1, C=1, Z=0. acc0, acc2 and acc3 remain 0. res_valid pulses on both ops in consecutive cycles.
- SUB equal: acc2=3, SUB 3 → acc2=0, Z=1, C=0.
- SUB borrow: acc2=4, SUB 5 → acc2=0xF, C=1, Z=0.
- CMP: acc3=5, CMP 5 → Z=1, C=0, acc3 still 5.
- MUL: acc0=5, MUL 3 → in_ready low 4 cycles, then acc0=0xF, C=0, single res_valid. Next, acc0=6, MUL 3 → acc0=2, C=1.
- MUL with ignored input: in_valid held high with op=ADD while busy → ignored.
- Abort and bus gating: reset asserted 2 cycles into a MUL → no res_valid, acc0=0, in_ready=1 next cycle. out_en=0 → bus_out=0. out_en=1 → bus_out=last R.

Source files
------------

// File: rtl/acc_unit_pkg.sv
// Shared types for the accumulator execution unit: operation codes and FSM states.
package acc_unit_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_CMP  = 3'd6,
    OP_MUL  = 3'd7
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // CMP only updates the flags; every other op writes its result back.
  function automatic logic writes_acc(op_t o);
    return o != OP_CMP;
  endfunction

endpackage

// File: rtl/acc_unit_if.sv
// Operation handshake, operand/result buses and flag outputs of the accumulator unit.
interface acc_unit_if #(
  parameter int WIDTH = 4,
  parameter int NACC  = 4
);
  localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] bus_in;
  logic             out_en;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] acc_out;
  logic             res_valid;
  logic             busy;
  logic             C;
  logic             Z;

  modport master (
    output in_valid, op, sel, bus_in, out_en,
    input  in_ready, bus_out, acc_out, res_valid, busy, C, Z
  );

  modport slave (
    input  in_valid, op, sel, bus_in, out_en,
    output in_ready, bus_out, acc_out, res_valid, busy, C, Z
  );
endinterface

// File: rtl/acc_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, done pulses on the final step
// with the full product presented combinationally alongside it.
module acc_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNTW = $clog2(WIDTH);

  logic               run_p0;
  logic [CNTW-1:0]    cnt_p0;
  logic [2*WIDTH-1:0] mcand_p0;
  logic [2*WIDTH-1:0] part_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [2*WIDTH-1:0] step_sum;

  assign step_sum = part_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign done     = run_p0 && (cnt_p0 == '0);
  assign product  = step_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (start) begin
      run_p0 <= 1'b1;
      cnt_p0 <= CNTW'(WIDTH - 1);
    end else if (run_p0) begin
      if (cnt_p0 == '0) run_p0 <= 1'b0;
      else              cnt_p0 <= cnt_p0 - 1'b1;
    end
  end

  // operand / partial-product stage
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      mplier_p0 <= b;
      part_p0   <= '0;
    end else if (run_p0) begin
      part_p0   <= step_sum;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/acc_unit_n.sv
// Accumulator execution unit: NACC accumulators, single-cycle ALU, registered C/Z flags
// and result, with MUL delegated to a multi-cycle shift-add sequencer.
module acc_unit_n
  import acc_unit_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NACC  = 4
) (
  input logic       clk,
  input logic       reset,
  acc_unit_if.slave bus
);
  localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc_p0 [NACC];
  logic [WIDTH-1:0]   res_p0;
  logic               c_p0, z_p0, vld_p0;
  logic [SELW-1:0]    sel_p0;

  op_t                op_in;
  logic               accept, mul_start, mul_done;
  logic [WIDTH-1:0]   a_rd;
  logic [WIDTH:0]     alu_out;
  logic [2*WIDTH-1:0] mul_prod;

  logic               wr_acc, flag_en, c_nxt, z_nxt;
  logic [SELW-1:0]    wr_sel;
  logic [WIDTH-1:0]   wr_data;

  function automatic logic [WIDTH:0] alu_eval(op_t f, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (f)
      OP_LOAD:        r = {1'b0, b};
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      // MSB of the (WIDTH+1)-bit difference is the borrow
      OP_SUB, OP_CMP: r = {1'b0, a} - {1'b0, b};
      OP_AND:         r = {1'b0, a & b};
      OP_OR:          r = {1'b0, a | b};
      OP_XOR:         r = {1'b0, a ^ b};
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign op_in     = op_t'(bus.op);
  assign accept    = bus.in_valid && (state == ST_IDLE);
  assign mul_start = accept && (op_in == OP_MUL);
  assign a_rd      = (int'(bus.sel) < NACC) ? acc_p0[bus.sel] : '0;
  assign alu_out   = alu_eval(op_in, a_rd, bus.bus_in);

  acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_rd),
    .b       (bus.bus_in),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_nxt = state;
    wr_acc    = 1'b0;
    flag_en   = 1'b0;
    wr_sel    = bus.sel;
    wr_data   = alu_out[WIDTH-1:0];
    c_nxt     = alu_out[WIDTH];
    z_nxt     = (alu_out[WIDTH-1:0] == '0);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_in == OP_MUL) begin
            state_nxt = ST_MUL;
          end else begin
            flag_en = 1'b1;
            wr_acc  = writes_acc(op_in);
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_IDLE;
          flag_en   = 1'b1;
          wr_acc    = 1'b1;
          wr_sel    = sel_p0;
          wr_data   = mul_prod[WIDTH-1:0];
          c_nxt     = |mul_prod[2*WIDTH-1:WIDTH];
          z_nxt     = (mul_prod[WIDTH-1:0] == '0);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // writeback stage: accumulators, result register, flags, strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      res_p0 <= '0;
      c_p0   <= 1'b0;
      z_p0   <= 1'b0;
      vld_p0 <= 1'b0;
      sel_p0 <= '0;
      for (int i = 0; i < NACC; i++) acc_p0[i] <= '0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= flag_en;
      if (mul_start) sel_p0 <= bus.sel;
      if (flag_en) begin
        c_p0 <= c_nxt;
        z_p0 <= z_nxt;
      end
      if (wr_acc) begin
        res_p0 <= wr_data;
        for (int i = 0; i < NACC; i++)
          if (wr_sel == SELW'(i)) acc_p0[i] <= wr_data;
      end
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.res_valid = vld_p0;
  assign bus.C         = c_p0;
  assign bus.Z         = z_p0;
  assign bus.acc_out   = a_rd;
  assign bus.bus_out   = bus.out_en ? res_p0 : '0;

endmodule

// File: tb/tb_acc_unit_n.sv
// Directed scoreboard bench for acc_unit_n (WIDTH=4, NACC=4).
module tb_acc_unit_n;
  import acc_unit_pkg::*;

  localparam int WIDTH = 4;
  localparam int NACC  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  acc_unit_if #(.WIDTH(WIDTH), .NACC(NACC)) bus ();

  acc_unit_n #(.WIDTH(WIDTH), .NACC(NACC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.res_valid) begin
      if (sb.size() == 0) begin
        check("unexpected res_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("res C", 32'(bus.C), 32'(e.c));
        check("res Z", 32'(bus.Z), 32'(e.z));
        if (bus.out_en) check("res R", 32'(bus.bus_out), 32'(e.r));
      end
    end
  end

  task automatic issue(input op_t o, input int s, input logic [3:0] b,
                       input logic [3:0] er, input logic ec, input logic ez);
    exp_t e;
    e.r = er; e.c = ec; e.z = ez;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.sel      = 2'(s);
    bus.bus_in   = b;
    if (writes_acc(o) || o == OP_CMP) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic acc_is(input int s, input logic [3:0] v);
    bus.sel = 2'(s);
    #1;
    check($sformatf("acc%0d", s), 32'(bus.acc_out), 32'(v));
  endtask

  // MUL with in_valid held high (op=ADD, different bus_in) for the whole busy window.
  task automatic mul_op(input int s, input logic [3:0] b,
                        input logic [3:0] er, input logic ec, input logic ez);
    exp_t e;
    int   low;
    bit   got;
    e.r = er; e.c = ec; e.z = ez;
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.sel      = 2'(s);
    bus.bus_in   = b;
    sb.push_back(e);
    @(posedge clk); #1;
    check("mul busy", 32'(bus.busy), 32'd1);
    bus.op     = OP_ADD;
    bus.bus_in = 4'h7;
    low = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!bus.in_ready) low++;
      if (bus.res_valid) got = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("mul done seen", 32'(got), 32'd1);
    check("mul in_ready low cycles", 32'(low), 32'd4);
    check("mul in_ready back", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op       = OP_LOAD;
    bus.sel      = '0;
    bus.bus_in   = '0;
    bus.out_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst C", 32'(bus.C), 32'd0);
    check("rst Z", 32'(bus.Z), 32'd0);
    check("rst res_valid", 32'(bus.res_valid), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst bus_out", 32'(bus.bus_out), 32'd0);
    for (int i = 0; i < NACC; i++) acc_is(i, 4'h0);
    @(posedge clk); #1;

    // LOAD then ADD back-to-back with carry out
    issue(OP_LOAD, 1, 4'h9, 4'h9, 1'b0, 1'b0);
    issue(OP_ADD,  1, 4'h8, 4'h1, 1'b1, 1'b0);
    check("add res_valid 2nd cycle", 32'(bus.res_valid), 32'd1);
    acc_is(1, 4'h1);
    acc_is(0, 4'h0);
    acc_is(2, 4'h0);
    acc_is(3, 4'h0);

    issue(OP_LOAD, 2, 4'h3, 4'h3, 1'b0, 1'b0);
    issue(OP_SUB,  2, 4'h3, 4'h0, 1'b0, 1'b1);
    acc_is(2, 4'h0);

    issue(OP_LOAD, 2, 4'h4, 4'h4, 1'b0, 1'b0);
    issue(OP_SUB,  2, 4'h5, 4'hF, 1'b1, 1'b0);
    acc_is(2, 4'hF);

    // CMP leaves the result register at the previous LOAD value
    issue(OP_LOAD, 3, 4'h5, 4'h5, 1'b0, 1'b0);
    issue(OP_CMP,  3, 4'h5, 4'h5, 1'b0, 1'b1);
    acc_is(3, 4'h5);

    issue(OP_LOAD, 0, 4'h5, 4'h5, 1'b0, 1'b0);
    mul_op(0, 4'h3, 4'hF, 1'b0, 1'b0);
    acc_is(0, 4'hF);

    issue(OP_LOAD, 0, 4'h6, 4'h6, 1'b0, 1'b0);
    mul_op(0, 4'h3, 4'h2, 1'b1, 1'b0);
    acc_is(0, 4'h2);

    // product 16: low half zero, high half nonzero
    issue(OP_LOAD, 3, 4'h4, 4'h4, 1'b0, 1'b0);
    mul_op(3, 4'h4, 4'h0, 1'b1, 1'b1);
    acc_is(3, 4'h0);

    // Reset two cycles into a MUL aborts it without a strobe
    issue(OP_LOAD, 0, 4'h5, 4'h5, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.sel      = 2'd0;
    bus.bus_in   = 4'h3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort res_valid", 32'(bus.res_valid), 32'd0);
    check("abort C", 32'(bus.C), 32'd0);
    acc_is(0, 4'h0);
    repeat (6) @(posedge clk);
    #1;
    check("abort idle", 32'(bus.in_ready), 32'd1);

    // Output bus gating
    issue(OP_LOAD, 1, 4'hA, 4'hA, 1'b0, 1'b0);
    bus.out_en = 1'b0;
    #1 check("bus_out gated", 32'(bus.bus_out), 32'd0);
    bus.out_en = 1'b1;
    #1 check("bus_out enabled", 32'(bus.bus_out), 32'hA);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
